// File: rtl/lieat_axi_sram_slave.sv
// Single-beat AXI4 slave in front of a word-wide synchronous SRAM.
// Independent read and write FSMs share one storage array; the read side has a programmable latency.
module lieat_axi_sram_slave #(
  parameter int              XLEN       = 32,
  parameter int              AXILEN     = 64,
  parameter int              DEPTH_LOG2 = 10,
  parameter logic [XLEN-1:0] BASE       = 32'h8000_0000,
  parameter int              RD_LAT     = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [XLEN-1:0]     awaddr,
  input  logic [3:0]          awid,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [AXILEN-1:0]   wdata,
  input  logic [AXILEN/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  output logic [3:0]          bid,
  input  logic                arvalid,
  output logic                arready,
  input  logic [XLEN-1:0]     araddr,
  input  logic [3:0]          arid,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [AXILEN-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic [3:0]          rid,
  output logic                rlast
);

  localparam int              BYTE_SHIFT = $clog2(AXILEN / 8);
  localparam int              IDX_HI     = DEPTH_LOG2 + 2;
  localparam int              CNT_W      = 8;
  localparam logic [XLEN:0]   WIN_SIZE   = (XLEN + 1)'(1) << (DEPTH_LOG2 + BYTE_SHIFT);
  localparam logic [1:0]      RESP_OKAY  = 2'b00;
  localparam logic [1:0]      RESP_SLV   = 2'b10;
  localparam logic [1:0]      RESP_DEC   = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic       {W_IDLE, W_RESP}         w_state_t;

  // Window compare is done one bit wider so BASE + size cannot wrap.
  function automatic logic in_window(input logic [XLEN-1:0] addr);
    logic [XLEN:0] a, lo;
    a  = {1'b0, addr};
    lo = {1'b0, BASE};
    return (a >= lo) && (a < lo + WIN_SIZE);
  endfunction

  function automatic logic [1:0] resp_of(input logic [XLEN-1:0] addr, input logic [7:0] len);
    if (!in_window(addr))  return RESP_DEC;
    else if (len != 8'd0)  return RESP_SLV;
    else                   return RESP_OKAY;
  endfunction

  logic [AXILEN-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

  r_state_t               r_state, r_next;
  w_state_t               w_state, w_next;
  logic [CNT_W-1:0]       rd_cnt;
  logic [DEPTH_LOG2-1:0]  ar_idx_q, aw_idx_q, wr_idx;
  logic [3:0]             ar_id_q, aw_id_q, wr_id;
  logic [1:0]             ar_resp_q, aw_resp_q, wr_resp;
  logic [AXILEN-1:0]      w_data_q, wr_data;
  logic [AXILEN/8-1:0]    w_strb_q, wr_strb;
  logic                   aw_got, w_got;
  logic                   ar_fire, aw_fire, w_fire, commit, rd_done;

  logic unused_ok;
  assign unused_ok = ^{awsize, awburst, arsize, arburst, wlast};

  assign ar_fire = arvalid & arready;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign rd_done = (r_state == R_WAIT) && (rd_cnt == '0);

  // Read FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  // Read FSM: next state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_WAIT;
      R_WAIT:  if (rd_done) r_next = R_RESP;
      R_RESP:  if (rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_RESP);
    rlast   = (r_state == R_RESP);
  end

  // The R_WAIT -> R_RESP edge is the SRAM read; a write committing on the same edge is not yet visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_cnt <= '0;
      rdata  <= '0;
      rid    <= '0;
      rresp  <= '0;
    end else begin
      if (ar_fire)
        rd_cnt <= CNT_W'(RD_LAT - 1);
      else if ((r_state == R_WAIT) && (rd_cnt != '0))
        rd_cnt <= rd_cnt - CNT_W'(1);
      if (rd_done) begin
        rdata <= (ar_resp_q == RESP_OKAY) ? mem[ar_idx_q] : '0;
        rid   <= ar_id_q;
        rresp <= ar_resp_q;
      end
    end
  end

  // A beat captured earlier wins; otherwise the one handshaking this cycle feeds the commit directly.
  always_comb begin
    wr_idx  = aw_got ? aw_idx_q  : awaddr[IDX_HI:3];
    wr_id   = aw_got ? aw_id_q   : awid;
    wr_resp = aw_got ? aw_resp_q : resp_of(awaddr, awlen);
    wr_data = w_got  ? w_data_q  : wdata;
    wr_strb = w_got  ? w_strb_q  : wstrb;
    commit  = (w_state == W_IDLE) && (aw_got || aw_fire) && (w_got || w_fire);
  end

  // Write FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
    end else begin
      w_state <= w_next;
      if (commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bid    <= wr_id;
        bresp  <= wr_resp;
      end else begin
        if (aw_fire) aw_got <= 1'b1;
        if (w_fire)  w_got  <= 1'b1;
      end
    end
  end

  // Write FSM: next state
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    awready = (w_state == W_IDLE) && !aw_got;
    wready  = (w_state == W_IDLE) && !w_got;
    bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge clock) begin
    if (ar_fire) begin
      ar_idx_q  <= araddr[IDX_HI:3];
      ar_id_q   <= arid;
      ar_resp_q <= resp_of(araddr, arlen);
    end
    if (aw_fire) begin
      aw_idx_q  <= awaddr[IDX_HI:3];
      aw_id_q   <= awid;
      aw_resp_q <= resp_of(awaddr, awlen);
    end
    if (w_fire) begin
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end
  end

  // A commit landing together with reset is dropped, so no partial write survives.
  always_ff @(posedge clock) begin
    if (commit && (wr_resp == RESP_OKAY) && !reset) begin
      for (int b = 0; b < AXILEN / 8; b++)
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_lieat_axi_sram_slave.sv
// Directed bench for lieat_axi_sram_slave: stimulus pushes expected R/B responses,
// a negedge monitor pops and compares them as the DUT presents each beat.
module tb_lieat_axi_sram_slave;

  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast, wlast;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, arid, bid, rid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;

  typedef struct { logic [63:0] data; logic [3:0] id; logic [1:0] resp; } r_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;

  r_exp_t rq[$];
  b_exp_t bq[$];
  r_exp_t r_e;
  b_exp_t b_e;
  int checks = 0;
  int errors = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] prev_rdata;
  logic [3:0]  prev_rid;
  logic [1:0]  prev_rresp;

  always #5 clock = ~clock;

  lieat_axi_sram_slave #(.RD_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops plus R-channel stability while stalled
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("r_hold_valid", {63'd0, rvalid}, 64'd1);
        chk("r_hold_data", rdata, prev_rdata);
        chk("r_hold_id", {60'd0, rid}, {60'd0, prev_rid});
        chk("r_hold_resp", {62'd0, rresp}, {62'd0, prev_rresp});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got beat id %h expected none", rid);
        end else begin
          r_e = rq.pop_front();
          chk("r_data", rdata, r_e.data);
          chk("r_id", {60'd0, rid}, {60'd0, r_e.id});
          chk("r_resp", {62'd0, rresp}, {62'd0, r_e.resp});
          chk("r_last", {63'd0, rlast}, 64'd1);
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got id %h expected none", bid);
        end else begin
          b_e = bq.pop_front();
          chk("b_id", {60'd0, bid}, {60'd0, b_e.id});
          chk("b_resp", {62'd0, bresp}, {62'd0, b_e.resp});
        end
      end
      stall_prev = rvalid && !rready;
      prev_rdata = rdata;
      prev_rid   = rid;
      prev_rresp = rresp;
    end
  end

  task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    awaddr = a; awid = id; awlen = len; awvalid = 1'b1;
    while (1) begin
      @(negedge clock);
      if (awready || n > 30) break;
      n++;
    end
    chk("aw_accept", {63'd0, awready}, 64'd1);
    @(posedge clock); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (1) begin
      @(negedge clock);
      if (wready || n > 30) break;
      n++;
    end
    chk("w_accept", {63'd0, wready}, 64'd1);
    @(posedge clock); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    araddr = a; arid = id; arlen = len; arvalid = 1'b1;
    while (1) begin
      @(negedge clock);
      if (arready || n > 30) break;
      n++;
    end
    chk("ar_accept", {63'd0, arready}, 64'd1);
    @(posedge clock); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 60) begin
      @(posedge clock); n++;
    end
    #1;
    chk("drain", 64'(rq.size() + bq.size()), 64'd0);
  endtask

  task automatic write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                       input logic [63:0] d, input logic [7:0] s, input logic [1:0] resp);
    bq.push_back('{id: id, resp: resp});
    fork
      send_aw(a, id, len);
      send_w(d, s);
    join
    drain();
  endtask

  task automatic read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                      input logic [63:0] d, input logic [1:0] resp);
    rq.push_back('{data: d, id: id, resp: resp});
    send_ar(a, id, len);
    drain();
  endtask

  initial begin
    int lat;
    int n;
    reset = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; rready = 1; bready = 1;
    awaddr = 0; awid = 0; awlen = 0; awsize = 3'd3; awburst = 2'b01;
    wdata = 0; wstrb = 0; wlast = 1;
    araddr = 0; arid = 0; arlen = 0; arsize = 3'd3; arburst = 2'b01;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_arready", {63'd0, arready}, 64'd1);
    chk("rst_awready", {63'd0, awready}, 64'd1);
    chk("rst_wready", {63'd0, wready}, 64'd1);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rid_rresp", {58'd0, rid, rresp}, 64'd0);
    chk("rst_bid_bresp", {58'd0, bid, bresp}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // T1: full write then read, latency measured from AR accept
    write(32'h8000_0010, 4'd1, 8'd0, 64'h1122_3344_5566_7788, 8'hFF, 2'b00);
    rq.push_back('{data: 64'h1122_3344_5566_7788, id: 4'd2, resp: 2'b00});
    send_ar(32'h8000_0010, 4'd2, 8'd0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clock); #1; lat++;
      if (rvalid) break;
    end
    chk("rd_latency", 64'(lat), 64'(LAT));
    drain();

    // T2: W three cycles ahead of AW, low half strobed
    bq.push_back('{id: 4'd3, resp: 2'b00});
    send_w(64'hFFFF_FFFF_AAAA_AAAA, 8'h0F);
    chk("t2_wready_low", {63'd0, wready}, 64'd0);
    chk("t2_awready_high", {63'd0, awready}, 64'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("t2_no_early_b", {63'd0, bvalid}, 64'd0);
    send_aw(32'h8000_0010, 4'd3, 8'd0);
    drain();
    read(32'h8000_0010, 4'd2, 8'd0, 64'h1122_3344_AAAA_AAAA, 2'b00);

    // T3: out-of-window decode errors; aliasing write must not land
    read(32'h0000_0100, 4'd2, 8'd0, 64'd0, 2'b11);
    write(32'h9000_0010, 4'd1, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b11);
    read(32'h8000_0010, 4'd4, 8'd0, 64'h1122_3344_AAAA_AAAA, 2'b00);
    read(32'h8000_2000, 4'd4, 8'd0, 64'd0, 2'b11);
    read(32'h7FFF_FFF8, 4'd4, 8'd0, 64'd0, 2'b11);
    write(32'h8000_1FF8, 4'd5, 8'd0, 64'h5555_6666_7777_8888, 8'hFF, 2'b00);
    read(32'h8000_1FF8, 4'd5, 8'd0, 64'h5555_6666_7777_8888, 2'b00);

    // T4: burst requests give one SLVERR beat and no write; DECERR wins
    read(32'h8000_0010, 4'd6, 8'd3, 64'd0, 2'b10);
    repeat (4) @(posedge clock);
    #1;
    chk("t4_single_beat", {63'd0, rvalid}, 64'd0);
    read(32'h0000_0100, 4'd6, 8'd2, 64'd0, 2'b11);
    write(32'h8000_0010, 4'd7, 8'd1, 64'd0, 8'hFF, 2'b10);
    read(32'h8000_0010, 4'd8, 8'd0, 64'h1122_3344_AAAA_AAAA, 2'b00);

    // T5: back-pressure on R
    rready = 1'b0;
    rq.push_back('{data: 64'h1122_3344_AAAA_AAAA, id: 4'd9, resp: 2'b00});
    send_ar(32'h8000_0010, 4'd9, 8'd0);
    n = 0;
    while (!rvalid && n < 20) begin
      @(posedge clock); #1; n++;
    end
    chk("t5_rvalid_rise", {63'd0, rvalid}, 64'd1);
    repeat (5) begin
      @(posedge clock); #1;
      chk("t5_rvalid_held", {63'd0, rvalid}, 64'd1);
      chk("t5_arready_low", {63'd0, arready}, 64'd0);
    end
    rready = 1'b1;
    drain();
    chk("t5_arready_back", {63'd0, arready}, 64'd1);

    // T6: reset during R_WAIT and during W_RESP
    send_ar(32'h8000_0010, 4'd10, 8'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("t6_rvalid_in_rst", {63'd0, rvalid}, 64'd0);
    chk("t6_arready_in_rst", {63'd0, arready}, 64'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (LAT + 1) @(posedge clock);
    #1;
    chk("t6_no_stale_r", {63'd0, rvalid}, 64'd0);
    bready = 1'b0;
    fork
      send_aw(32'h8000_0018, 4'd11, 8'd0);
      send_w(64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    join
    n = 0;
    while (!bvalid && n < 20) begin
      @(posedge clock); #1; n++;
    end
    chk("t6_bvalid_pre", {63'd0, bvalid}, 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_bvalid_in_rst", {63'd0, bvalid}, 64'd0);
    chk("t6_readies_in_rst", {61'd0, awready, wready, arready}, 64'd7);
    @(posedge clock); #1;
    reset = 1'b0;
    bready = 1'b1;
    @(posedge clock); #1;
    chk("t6_bvalid_after", {63'd0, bvalid}, 64'd0);

    // Back to normal operation, including a sparse strobe
    write(32'h8000_0018, 4'd12, 8'd0, 64'h0F1E_2D3C_4B5A_6978, 8'hFF, 2'b00);
    write(32'h8000_0018, 4'd12, 8'd0, 64'h9900_0000_0000_00EE, 8'h81, 2'b00);
    read(32'h8000_0018, 4'd13, 8'd0, 64'h991E_2D3C_4B5A_69EE, 2'b00);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
